// File: rtl/clk_div_prog.sv
// Programmable clock divider.
// Produces a registered divided clock (div_out) with period N, high for
// ceil(N/2) cycles, plus a one-cycle tick at the start of every period.
// New divisors are staged in a pending register and are applied only at a
// period boundary, or immediately while the divider is halted.
module clk_div_prog #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0] div_cur_q,  div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q,     pend_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             div_out_q,  div_out_d;
  logic             tick_q,     tick_d;
  logic             div_ack_q,  div_ack_d;

  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] last_cnt;
  logic             terminal;

  // Effective divisor, high-phase length and period-end detection.
  // A divisor of 0 behaves as 1. high_len = (N>>1)+(N&1) never exceeds
  // 2^(CNT_W-1), so it fits in CNT_W bits without a carry.
  always_comb begin
    n_eff    = (div_cur_q == '0) ? ONE_C : div_cur_q;
    high_len = (n_eff >> 1) + {{(CNT_W-1){1'b0}}, n_eff[0]};
    last_cnt = n_eff - ONE_C;
    terminal = en && (cnt_q == last_cnt);
  end

  // Next-state logic for the counter, outputs and divisor staging.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    div_out_d  = div_out_q;
    tick_d     = tick_q;
    div_ack_d  = div_load;

    if (div_load) begin
      div_pend_d = div_val;
    end

    if (en) begin
      cnt_d     = terminal ? '0 : cnt_q + ONE_C;
      div_out_d = (cnt_q < high_len);
      tick_d    = (cnt_q == '0);
      if (terminal) begin
        // Boundary: a load arriving now bypasses the pending register.
        if (div_load) begin
          div_cur_d = div_val;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          div_cur_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else if (div_load) begin
        pend_d = 1'b1;
      end
    end else begin
      // Halted: abort the period; a staged divisor takes effect at once,
      // a load seen now is staged and applied on the following cycle.
      cnt_d     = '0;
      div_out_d = 1'b0;
      tick_d    = 1'b0;
      pend_d    = div_load;
      if (pend_q) begin
        div_cur_d = div_pend_q;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cur_q  <= DEF_DIV_C;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      div_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_ack_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, independent of statement order.
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      div_out_q  <= div_out_d;
      tick_q     <= tick_d;
      div_ack_q  <= div_ack_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;
  assign div_ack = div_ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog: a table of divisor loads with
// hand-computed high/low phase lengths, plus hand-written sequences for
// reset, boundary bypass, last-write-wins, halt and mid-period reset.
module tb_clk_div_prog;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
  logic        div_ack;
  logic        div_out;
  logic        tick;

  int tests_run;
  int tests_failed;
  int cyc;

  typedef struct {
    logic [15:0] div;
    int          hi;
    int          lo;
  } vec_t;

  vec_t vecs[8];

  clk_div_prog #(
    .CNT_W  (16),
    .DEF_DIV(64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .div_ack (div_ack),
    .div_out (div_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (tick !== 1'b1) check({name, " tick timeout"}, int'(tick), 1);
  endtask

  // Measure one full period starting at a tick: high count, low count,
  // and any div_ack pulses seen inside it. Also flags a non-contiguous
  // high phase.
  task automatic measure(input string name, output int hi, output int lo,
                         output int acks);
    int guard;
    bit dropped;
    bit bad;
    wait_tick(name);
    hi = 0; lo = 0; acks = 0; guard = 0; dropped = 0; bad = 0;
    do begin
      if (div_out === 1'b1) begin
        hi++;
        if (dropped) bad = 1'b1;
      end else begin
        lo++;
        dropped = 1'b1;
      end
      if (div_ack === 1'b1) acks++;
      step();
      guard++;
    end while (tick !== 1'b1 && guard < 2000);
    check({name, " shape"}, int'(bad), 0);
    check({name, " period end"}, int'(tick), 1);
  endtask

  task automatic apply_vec(input logic [15:0] dv, input int ehi,
                           input int elo, input string name);
    int hi, lo, acks;
    div_val  = dv;
    div_load = 1'b1;
    step();
    check({name, " ack"}, int'(div_ack), 1);
    div_load = 1'b0;
    step();
    check({name, " ack low"}, int'(div_ack), 0);
    wait_tick(name);
    step();
    measure(name, hi, lo, acks);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
  endtask

  initial begin
    int hi, lo, acks, t0;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;

    vecs[0] = '{div: 16'd1,   hi: 1,   lo: 0};
    vecs[1] = '{div: 16'd0,   hi: 1,   lo: 0};
    vecs[2] = '{div: 16'd7,   hi: 4,   lo: 3};
    vecs[3] = '{div: 16'd2,   hi: 1,   lo: 1};
    vecs[4] = '{div: 16'd3,   hi: 2,   lo: 1};
    vecs[5] = '{div: 16'd9,   hi: 5,   lo: 4};
    vecs[6] = '{div: 16'd200, hi: 100, lo: 100};
    vecs[7] = '{div: 16'd4,   hi: 2,   lo: 2};

    // Reset with a load strobe held high: outputs low, load discarded.
    rst_n    = 1'b0;
    en       = 1'b1;
    div_val  = 16'd5;
    div_load = 1'b1;
    step();
    step();
    check("rst div_out", int'(div_out), 0);
    check("rst tick", int'(tick), 0);
    check("rst div_ack", int'(div_ack), 0);

    rst_n    = 1'b1;
    div_load = 1'b0;
    step();
    check("first tick", int'(tick), 1);
    check("first div_out", int'(div_out), 1);
    check("no ack after rst", int'(div_ack), 0);
    measure("def64", hi, lo, acks);
    check("def64 hi", hi, 32);
    check("def64 lo", lo, 32);
    check("def64 acks", acks, 0);

    // Load 5 at cnt=10 of a 64 period: current period runs to 64.
    t0 = cyc;
    repeat (9) step();
    div_val  = 16'd5;
    div_load = 1'b1;
    step();
    check("n5 ack", int'(div_ack), 1);
    div_load = 1'b0;
    step();
    check("n5 ack low", int'(div_ack), 0);
    wait_tick("n5");
    check("n5 old period", cyc - t0, 64);
    measure("n5", hi, lo, acks);
    check("n5 hi", hi, 3);
    check("n5 lo", lo, 2);

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i].div, vecs[i].hi, vecs[i].lo,
                $sformatf("vec%0d n=%0d", i, vecs[i].div));
    end

    // N=4 is active, sampled at a tick (cnt=1). Load 7 at the terminal
    // cycle (cnt=3): the period stays 4, the next one is already 7.
    t0 = cyc;
    step();
    step();
    div_val  = 16'd7;
    div_load = 1'b1;
    step();
    check("byp ack", int'(div_ack), 1);
    div_load = 1'b0;
    step();
    check("byp tick", int'(tick), 1);
    check("byp old period", cyc - t0, 4);
    measure("byp7", hi, lo, acks);
    check("byp7 hi", hi, 4);
    check("byp7 lo", lo, 3);

    // Two back-to-back loads while pending: both acked, the last wins.
    div_val  = 16'd3;
    div_load = 1'b1;
    step();
    check("lww ack1", int'(div_ack), 1);
    div_val  = 16'd11;
    step();
    check("lww ack2", int'(div_ack), 1);
    div_load = 1'b0;
    step();
    check("lww ack low", int'(div_ack), 0);
    measure("lww11", hi, lo, acks);
    check("lww11 hi", hi, 6);
    check("lww11 lo", lo, 5);

    // Halt at cnt=10 of N=64 with N=6 pending.
    apply_vec(16'd64, 32, 32, "re64");
    div_val  = 16'd6;
    div_load = 1'b1;
    step();
    check("halt ack", int'(div_ack), 1);
    div_load = 1'b0;
    repeat (8) step();
    en = 1'b0;
    step();
    check("halt div_out", int'(div_out), 0);
    check("halt tick", int'(tick), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("halt hold %0d", i), int'(div_out | tick), 0);
    end
    en = 1'b1;
    step();
    check("resume tick", int'(tick), 1);
    check("resume div_out", int'(div_out), 1);
    measure("resume6", hi, lo, acks);
    check("resume6 hi", hi, 3);
    check("resume6 lo", lo, 3);

    // Mid-period reset with a divisor pending.
    div_val  = 16'd9;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("pre-rst div_out", int'(div_out), 1);
    check("pre-rst ack", int'(div_ack), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst div_out", int'(div_out), 0);
    check("async rst ack", int'(div_ack), 0);
    check("async rst tick", int'(tick), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post-rst tick", int'(tick), 1);
    measure("post-rst", hi, lo, acks);
    check("post-rst hi", hi, 32);
    check("post-rst lo", lo, 32);
    check("post-rst acks", acks, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 16: width of the divisor and of the internal period counter.
REQ-002 Parameter DEF_DIV, default 64: divisor in effect after reset; SHALL be in 1..2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run enable; 1 = divide, 0 = halted.
REQ-006 div_val  input  CNT_W  requested divisor N, unsigned.
REQ-007 div_load  input  1  single-cycle strobe requesting capture of div_val.
REQ-008 div_ack  output  1  one-cycle pulse confirming a div_load capture.
REQ-009 div_out  output  1  registered divided clock.
REQ-010 tick  output  1  registered one-cycle pulse marking each output period start.

Function
REQ-011 Internal state SHALL be: div_cur (active divisor), div_pend (pending divisor), pend (pending flag), cnt (period counter, CNT_W bits).
REQ-012 The effective divisor N SHALL be div_cur, except that div_cur = 0 SHALL be treated as N = 1.
REQ-013 High phase length H SHALL be (N>>1)+(N&1), computed without overflow in CNT_W bits; low phase = N-H.
REQ-014 Running (en=1): cnt SHALL count 0,1,..,N-1 and wrap to 0; the cycle with cnt = N-1 is the terminal cycle.
REQ-015 Running: div_out(t+1) SHALL equal (cnt(t) < H), giving period N, H cycles high then N-H low, one cycle latency from cnt.
REQ-016 Running: tick(t+1) SHALL equal (cnt(t) = 0); exactly one tick per output period, coincident with the div_out rising cycle.
REQ-017 N = 1: cnt SHALL remain 0, div_out SHALL stay 1 and tick SHALL be 1 every cycle while en=1.
REQ-018 div_load = 1 in any cycle (independent of en) SHALL capture div_val into div_pend and set pend; div_ack SHALL be 1 in the following cycle only.
REQ-019 A div_load while pend is already set SHALL overwrite div_pend (last write wins) and SHALL produce its own div_ack.
REQ-020 Running: at a terminal cycle with pend set, div_cur SHALL take div_pend and pend SHALL clear; the new N governs from cnt = 0 of the next period; the current period is never truncated or stretched.
REQ-021 div_load coinciding with a terminal cycle SHALL apply div_val directly to div_cur at that boundary (bypass); pend SHALL remain 0; div_ack still pulses.
REQ-022 Halted (en=0): cnt SHALL be forced to 0, div_out and tick SHALL be 0 from the next cycle, and a pending divisor SHALL be applied to div_cur immediately (div_load during halt applies on the following cycle).
REQ-023 en rising: the first enabled cycle SHALL have cnt = 0, so tick and div_out rise one cycle after en rises.
REQ-024 en falling mid-period SHALL abort the period without completing it; no partial tick is emitted.

Reset
REQ-025 rst_n = 0 SHALL immediately force: div_cur = DEF_DIV, div_pend = 0, pend = 0, cnt = 0, div_out = 0, tick = 0, div_ack = 0.
REQ-026 A div_load asserted in the same cycle as reset is active SHALL be discarded.
REQ-027 Reset asserted mid-period SHALL discard the period and any pending divisor; after release the block resumes with DEF_DIV from cnt = 0 if en = 1.

Verification
REQ-028 Reset release with en=1, DEF_DIV=64 -> div_out 32 high / 32 low, tick every 64 cycles, first tick 1 cycle after first enabled edge.
REQ-029 Load N=5 mid-period of N=64 -> div_ack next cycle; current 64-cycle period completes; then div_out 3 high / 2 low, period 5.
REQ-030 Load N=1 then N=0 -> div_out constant 1, tick every cycle in both cases.
REQ-031 Load N=7 at terminal cycle of N=4 -> next period is already 7 (4 high / 3 low); pend stays 0.
REQ-032 en dropped at cnt=10 of N=64 with N=6 pending -> div_out/tick 0 next cycle; en re-asserted -> 3 high / 3 low from first period.
REQ-033 rst_n asserted mid-period with pend set -> outputs 0 asynchronously; after release, period 64 and no div_ack.
